dc_ipu_filter_scan_ctrl: RTL and testbench

Output-raster scan controller for the IPU bicubic filter. Per output pixel it steps a fixed-point DDA in x and y, then emits one beat to the texel-fetch and filter stages over a valid/ready handshake. Each beat carries:
- the integer source coordinate of the 4x4 window anchor;
- the fractional coefficients coeff_x / coeff_y.

It sequences one frame per start command and sits upstream of the texel-matrix fetch and the filter weight pipeline.

---
 rtl/dc_ipu_filter_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_dc_ipu_filter_scan_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_ipu_filter_scan_ctrl.sv
// Output-raster scan controller: steps an x/y fixed-point DDA and emits one filter beat per output pixel.
// Optional source-coordinate clamping is enabled by defining DC_IPU_FILTER_SCAN_CLAMP_EN.
module dc_ipu_filter_scan_ctrl #(
    parameter int COORD_WIDTH      = 12,
    parameter int STEP_FRACT_WIDTH = 16,
    parameter int COEFF_WIDTH      = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  clr,
    input  logic                                  start,
    input  logic [COORD_WIDTH-1:0]                cfg_out_width,
    input  logic [COORD_WIDTH-1:0]                cfg_out_height,
    input  logic [COORD_WIDTH-1:0]                cfg_src_width,
    input  logic [COORD_WIDTH-1:0]                cfg_src_height,
    input  logic [COORD_WIDTH+STEP_FRACT_WIDTH-1:0] cfg_step_x,
    input  logic [COORD_WIDTH+STEP_FRACT_WIDTH-1:0] cfg_step_y,
    input  logic [STEP_FRACT_WIDTH-1:0]           cfg_phase_x,
    input  logic [STEP_FRACT_WIDTH-1:0]           cfg_phase_y,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [COORD_WIDTH-1:0]                out_src_x,
    output logic [COORD_WIDTH-1:0]                out_src_y,
    output logic [COEFF_WIDTH-1:0]                out_coeff_x,
    output logic [COEFF_WIDTH-1:0]                out_coeff_y,
    output logic                                  out_last_x,
    output logic                                  out_last_frame
);
    localparam int ACC_W = COORD_WIDTH + STEP_FRACT_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state_q, state_d;
    logic [ACC_W-1:0]          acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [COORD_WIDTH-1:0]    col_q, col_d, row_q, row_d;
    logic [COORD_WIDTH-1:0]    width_q, height_q;
    logic [ACC_W-1:0]          step_x_q, step_y_q;
    logic [STEP_FRACT_WIDTH-1:0] phase_x_q, phase_y_q;
    logic                      start_ok, eol, eof;
    logic [COORD_WIDTH-1:0]    int_x, int_y;
    logic [COEFF_WIDTH-1:0]    frac_x, frac_y;

`ifdef DC_IPU_FILTER_SCAN_CLAMP_EN
    logic [COORD_WIDTH-1:0]    src_w_q, src_h_q;
    logic [COORD_WIDTH-1:0]    lim_x, lim_y;
`else
    logic                      unused_src;
    assign unused_src = ^{cfg_src_width, cfg_src_height};
`endif

    // Largest legal source index; a zero dimension behaves like one pixel.
    function automatic logic [COORD_WIDTH-1:0] coord_limit(input logic [COORD_WIDTH-1:0] dim);
        return (dim == '0) ? '0 : dim - COORD_WIDTH'(1);
    endfunction

    assign start_ok = (state_q == IDLE) && start && (cfg_out_width != '0) && (cfg_out_height != '0);
    assign eol      = (col_q == width_q - COORD_WIDTH'(1));
    assign eof      = eol && (row_q == height_q - COORD_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = RUN;
                    acc_x_d = {{COORD_WIDTH{1'b0}}, cfg_phase_x};
                    acc_y_d = {{COORD_WIDTH{1'b0}}, cfg_phase_y};
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (eol) begin
                        acc_x_d = {{COORD_WIDTH{1'b0}}, phase_x_q};
                        col_d   = '0;
                        acc_y_d = acc_y_q + step_y_q;
                        row_d   = row_q + COORD_WIDTH'(1);
                        if (eof) state_d = DONE;
                    end else begin
                        acc_x_d = acc_x_q + step_x_q;
                        col_d   = col_q + COORD_WIDTH'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            state_q  <= IDLE;
            acc_x_q  <= '0;
            acc_y_q  <= '0;
            col_q    <= '0;
            row_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
`ifdef DC_IPU_FILTER_SCAN_CLAMP_EN
            src_w_q  <= '0;
            src_h_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            col_q   <= col_d;
            row_q   <= row_d;
            if (start_ok) begin
                width_q  <= cfg_out_width;
                height_q <= cfg_out_height;
`ifdef DC_IPU_FILTER_SCAN_CLAMP_EN
                src_w_q  <= cfg_src_width;
                src_h_q  <= cfg_src_height;
`endif
            end
        end
    end

    // Step and phase only feed the accumulators, which are cleared on reset.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            step_x_q  <= cfg_step_x;
            step_y_q  <= cfg_step_y;
            phase_x_q <= cfg_phase_x;
            phase_y_q <= cfg_phase_y;
        end
    end

    assign int_x  = acc_x_q[ACC_W-1:STEP_FRACT_WIDTH];
    assign int_y  = acc_y_q[ACC_W-1:STEP_FRACT_WIDTH];
    assign frac_x = acc_x_q[STEP_FRACT_WIDTH-1 -: COEFF_WIDTH];
    assign frac_y = acc_y_q[STEP_FRACT_WIDTH-1 -: COEFF_WIDTH];

`ifdef DC_IPU_FILTER_SCAN_CLAMP_EN
    assign lim_x       = coord_limit(src_w_q);
    assign lim_y       = coord_limit(src_h_q);
    assign out_src_x   = (int_x > lim_x) ? lim_x : int_x;
    assign out_src_y   = (int_y > lim_y) ? lim_y : int_y;
    assign out_coeff_x = (int_x > lim_x) ? '0 : frac_x;
    assign out_coeff_y = (int_y > lim_y) ? '0 : frac_y;
`else
    assign out_src_x   = int_x;
    assign out_src_y   = int_y;
    assign out_coeff_x = frac_x;
    assign out_coeff_y = frac_y;
`endif

    assign out_last_x     = eol;
    assign out_last_frame = eof;
    assign out_valid      = (state_q == RUN);
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
endmodule

// File: tb/tb_dc_ipu_filter_scan_ctrl.sv
// Self-checking bench for dc_ipu_filter_scan_ctrl: directed scenarios plus randomized frames against a closed-form raster model.
module tb_dc_ipu_filter_scan_ctrl;
    localparam int CW = 12;
    localparam int FW = 16;
    localparam int KW = 8;
    localparam int AW = CW + FW;

    typedef longint unsigned u64_t;
    typedef struct packed {
        logic [CW-1:0] sx;
        logic [CW-1:0] sy;
        logic [KW-1:0] cx;
        logic [KW-1:0] cy;
        logic          lx;
        logic          lf;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1, clr = 1'b0, start = 1'b0, out_ready = 1'b1;
    logic [CW-1:0] cfg_out_width = '0, cfg_out_height = '0, cfg_src_width = '0, cfg_src_height = '0;
    logic [AW-1:0] cfg_step_x = '0, cfg_step_y = '0;
    logic [FW-1:0] cfg_phase_x = '0, cfg_phase_y = '0;
    logic busy, done, out_valid, out_last_x, out_last_frame;
    logic [CW-1:0] out_src_x, out_src_y;
    logic [KW-1:0] out_coeff_x, out_coeff_y;

    dc_ipu_filter_scan_ctrl #(.COORD_WIDTH(CW), .STEP_FRACT_WIDTH(FW), .COEFF_WIDTH(KW)) dut (
        .clk(clk), .reset(reset), .clr(clr), .start(start),
        .cfg_out_width(cfg_out_width), .cfg_out_height(cfg_out_height),
        .cfg_src_width(cfg_src_width), .cfg_src_height(cfg_src_height),
        .cfg_step_x(cfg_step_x), .cfg_step_y(cfg_step_y),
        .cfg_phase_x(cfg_phase_x), .cfg_phase_y(cfg_phase_y),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_src_x(out_src_x), .out_src_y(out_src_y),
        .out_coeff_x(out_coeff_x), .out_coeff_y(out_coeff_y),
        .out_last_x(out_last_x), .out_last_frame(out_last_frame)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc_cnt = 0, done_cnt = 0, done_cyc = 0, stall_viol = 0;
    logic done_busy = 1'b0, stall_prev = 1'b0;
    beat_t cur, stall_beat;
    beat_t got[$];
    int xcyc[$];

    assign cur = {out_src_x, out_src_y, out_coeff_x, out_coeff_y, out_last_x, out_last_frame};

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Transfers are recorded on the falling edge; they complete on the following rising edge.
    always @(negedge clk) begin
        if (reset || clr) begin
            stall_prev <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                got.push_back(cur);
                xcyc.push_back(cyc_cnt);
            end
            if (done) begin
                done_cnt  <= done_cnt + 1;
                done_cyc  <= cyc_cnt;
                done_busy <= busy;
            end
            if (stall_prev && out_valid && (cur !== stall_beat)) stall_viol <= stall_viol + 1;
            stall_prev <= out_valid && !out_ready;
            stall_beat <= cur;
        end
    end

    // Reference configuration used by the model.
    int m_w, m_h, m_srcw, m_srch;
    u64_t m_sx, m_sy, m_px, m_py;

    function automatic beat_t model(int col, int row);
        beat_t b;
        u64_t ax, ay, cx, cy;
        int ix, iy;
        ax = (m_px + u64_t'(col) * m_sx) % (u64_t'(1) << AW);
        ay = (m_py + u64_t'(row) * m_sy) % (u64_t'(1) << AW);
        ix = int'(ax >> FW);
        iy = int'(ay >> FW);
        cx = (ax >> (FW - KW)) & 64'hFF;
        cy = (ay >> (FW - KW)) & 64'hFF;
`ifdef DC_IPU_FILTER_SCAN_CLAMP_EN
        if (ix > ((m_srcw == 0) ? 0 : m_srcw - 1)) begin ix = (m_srcw == 0) ? 0 : m_srcw - 1; cx = 0; end
        if (iy > ((m_srch == 0) ? 0 : m_srch - 1)) begin iy = (m_srch == 0) ? 0 : m_srch - 1; cy = 0; end
`endif
        b.sx = ix[CW-1:0];
        b.sy = iy[CW-1:0];
        b.cx = cx[KW-1:0];
        b.cy = cy[KW-1:0];
        b.lx = (col == m_w - 1);
        b.lf = (col == m_w - 1) && (row == m_h - 1);
        return b;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int w, input int h, input logic [AW-1:0] sx, input logic [AW-1:0] sy,
                           input logic [FW-1:0] px, input logic [FW-1:0] py, input int srcw, input int srch);
        cfg_out_width  = w[CW-1:0];
        cfg_out_height = h[CW-1:0];
        cfg_step_x     = sx;
        cfg_step_y     = sy;
        cfg_phase_x    = px;
        cfg_phase_y    = py;
        cfg_src_width  = srcw[CW-1:0];
        cfg_src_height = srch[CW-1:0];
        m_w = w; m_h = h; m_sx = u64_t'(sx); m_sy = u64_t'(sy); m_px = u64_t'(px); m_py = u64_t'(py);
        m_srcw = srcw; m_srch = srch;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // mode 0: ready held high; 1: ready pattern 1,0,0 repeating; 2: random ready.
    task automatic run_until_done(input int budget, input int mode, output bit timeout);
        int d0;
        d0 = done_cnt;
        timeout = 1'b1;
        for (int i = 0; i < budget; i++) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (i % 3 == 0);
                default: out_ready = $urandom_range(0, 1) != 0;
            endcase
            cyc();
            if (done_cnt != d0) begin timeout = 1'b0; break; end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        int d0;
        reset = 1'b1;
        set_cfg(4, 2, 28'h08000, 28'h10000, 16'h0, 16'h0, 16, 16);
        repeat (3) cyc();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (cur !== '0) begin errors++; $display("FAIL reset_payload got %h exp 0", cur); end
        // Reset in the middle of a frame drops it without done.
        d0 = done_cnt;
        do_start();
        cyc(); cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b exp 0", busy); end
        checks++; if (cur !== '0) begin errors++; $display("FAIL midreset_payload got %h exp 0", cur); end
        repeat (3) cyc();
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL midreset_done got %0d exp %0d", done_cnt, d0); end
    endtask

    task automatic test_nominal();
        int sx_t[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
        int cx_t[8] = '{0, 128, 0, 128, 0, 128, 0, 128};
        int g0, s, d0;
        bit to;
        beat_t e;
        set_cfg(4, 2, 28'h08000, 28'h10000, 16'h0, 16'h0, 16, 16);
        g0 = got.size(); d0 = done_cnt; s = cyc_cnt;
        do_start();
        run_until_done(50, 0, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL nominal_timeout got %b exp 0", to); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_after got %b exp 0", busy); end
        checks++; if (got.size() - g0 !== 8) begin errors++; $display("FAIL nominal_count got %0d exp 8", got.size() - g0); end
        for (int i = 0; i < 8 && g0 + i < got.size(); i++) begin
            e = {sx_t[i][CW-1:0], CW'(i / 4), cx_t[i][KW-1:0], 8'd0, (i % 4 == 3), (i == 7)};
            checks++; if (got[g0+i] !== e) begin errors++; $display("FAIL nominal_beat%0d got %h exp %h", i, got[g0+i], e); end
        end
        if (got.size() - g0 == 8) begin
            checks++; if (xcyc[g0] !== s + 1) begin errors++; $display("FAIL nominal_first_cycle got %0d exp %0d", xcyc[g0], s + 1); end
            checks++; if (xcyc[g0+7] !== s + 8) begin errors++; $display("FAIL nominal_last_cycle got %0d exp %0d", xcyc[g0+7], s + 8); end
        end
        checks++; if (done_cyc !== s + 9) begin errors++; $display("FAIL nominal_done_cycle got %0d exp %0d", done_cyc, s + 9); end
        checks++; if (done_busy !== 1'b1) begin errors++; $display("FAIL nominal_done_busy got %b exp 1", done_busy); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL nominal_done_count got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        int g0, s;
        bit to;
        set_cfg(3, 2, 28'h0C000, 28'h18000, 16'h4000, 16'h2000, 16, 16);
        do_start();
        run_until_done(50, 0, to);
        g0 = got.size(); s = cyc_cnt;
        do_start();
        run_until_done(50, 0, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL b2b_timeout got %b exp 0", to); end
        checks++; if (got.size() - g0 !== 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", got.size() - g0); end
        if (got.size() - g0 == 6) begin
            checks++; if (xcyc[g0] !== s + 1) begin errors++; $display("FAIL b2b_first_cycle got %0d exp %0d", xcyc[g0], s + 1); end
            for (int i = 0; i < 6; i++) begin
                checks++; if (got[g0+i] !== model(i % 3, i / 3)) begin errors++; $display("FAIL b2b_beat%0d got %h exp %h", i, got[g0+i], model(i % 3, i / 3)); end
            end
        end
    endtask

    task automatic test_backpressure();
        int g0, d0, v0;
        bit to;
        set_cfg(4, 2, 28'h08000, 28'h10000, 16'h0, 16'h0, 16, 16);
        g0 = got.size(); d0 = done_cnt; v0 = stall_viol;
        do_start();
        run_until_done(200, 1, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout got %b exp 0", to); end
        checks++; if (got.size() - g0 !== 8) begin errors++; $display("FAIL bp_count got %0d exp 8", got.size() - g0); end
        for (int i = 0; i < 8 && g0 + i < got.size(); i++) begin
            checks++; if (got[g0+i] !== model(i % 4, i / 4)) begin errors++; $display("FAIL bp_beat%0d got %h exp %h", i, got[g0+i], model(i % 4, i / 4)); end
        end
        checks++; if (stall_viol - v0 !== 0) begin errors++; $display("FAIL bp_hold got %0d changes exp 0", stall_viol - v0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL bp_done_count got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_abort();
        int g0, d0, k;
        bit to;
        set_cfg(4, 2, 28'h08000, 28'h10000, 16'h0, 16'h0, 16, 16);
        g0 = got.size(); d0 = done_cnt;
        do_start();
        k = 0;
        while (got.size() - g0 < 3 && k < 20) begin cyc(); k++; end
        checks++; if (got.size() - g0 !== 3) begin errors++; $display("FAIL abort_reach3 got %0d exp 3", got.size() - g0); end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        repeat (3) cyc();
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL abort_no_done got %0d exp %0d", done_cnt, d0); end
        g0 = got.size();
        do_start();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_restart_valid got %b exp 1", out_valid); end
        checks++; if (cur !== beat_t'(0)) begin errors++; $display("FAIL abort_restart_beat got %h exp 0", cur); end
        run_until_done(50, 0, to);
        checks++; if (got.size() - g0 !== 8) begin errors++; $display("FAIL abort_restart_count got %0d exp 8", got.size() - g0); end
    endtask

    task automatic test_zero_dim();
        int d0;
        d0 = done_cnt;
        set_cfg(0, 2, 28'h10000, 28'h10000, 16'h0, 16'h0, 16, 16);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL zero_w_idle%0d got busy %b valid %b exp 0 0", i, busy, out_valid); end
            cyc();
        end
        set_cfg(3, 0, 28'h10000, 28'h10000, 16'h0, 16'h0, 16, 16);
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL zero_h_idle got busy %b valid %b exp 0 0", busy, out_valid); end
        cyc();
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL zero_no_done got %0d exp %0d", done_cnt, d0); end
    endtask

    task automatic test_start_busy();
        int g0, d0;
        bit to;
        set_cfg(3, 2, 28'h14000, 28'h0C000, 16'h1000, 16'h8000, 16, 16);
        g0 = got.size(); d0 = done_cnt;
        do_start();
        cyc(); cyc();
        cfg_out_width = 12'd5;
        cfg_phase_x = 16'hFFFF;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cfg_out_width = 12'd3;
        cfg_phase_x = 16'h1000;
        run_until_done(50, 0, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL busy_start_timeout got %b exp 0", to); end
        checks++; if (got.size() - g0 !== 6) begin errors++; $display("FAIL busy_start_count got %0d exp 6", got.size() - g0); end
        for (int i = 0; i < 6 && g0 + i < got.size(); i++) begin
            checks++; if (got[g0+i] !== model(i % 3, i / 3)) begin errors++; $display("FAIL busy_start_beat%0d got %h exp %h", i, got[g0+i], model(i % 3, i / 3)); end
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL busy_start_done got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_clamp();
`ifdef DC_IPU_FILTER_SCAN_CLAMP_EN
        int sx_t[5] = '{0, 1, 2, 2, 2};
        int cx_t[5] = '{128, 128, 128, 0, 0};
`else
        int sx_t[5] = '{0, 1, 2, 3, 4};
        int cx_t[5] = '{128, 128, 128, 128, 128};
`endif
        int g0;
        bit to;
        beat_t e;
        set_cfg(5, 1, 28'h10000, 28'h10000, 16'h8000, 16'h0, 3, 16);
        g0 = got.size();
        do_start();
        run_until_done(50, 0, to);
        checks++; if (got.size() - g0 !== 5) begin errors++; $display("FAIL clamp_count got %0d exp 5", got.size() - g0); end
        for (int i = 0; i < 5 && g0 + i < got.size(); i++) begin
            e = {sx_t[i][CW-1:0], 12'd0, cx_t[i][KW-1:0], 8'd0, (i == 4), (i == 4)};
            checks++; if (got[g0+i] !== e) begin errors++; $display("FAIL clamp_beat%0d got %h exp %h", i, got[g0+i], e); end
        end
    endtask

    task automatic test_random();
        int g0, d0, w, h, n;
        bit to;
        logic [AW-1:0] sx, sy;
        for (int f = 0; f < 8; f++) begin
            w = $urandom_range(1, 6);
            h = $urandom_range(1, 4);
            sx = AW'($urandom_range(0, 32'h3FFFF));
            sy = AW'($urandom_range(0, 32'h3FFFF));
            if (f == 7) begin
                sx = 28'hFFF0000 | AW'($urandom_range(0, 16'hFFFF));
                sy = 28'hFFE0000 | AW'($urandom_range(0, 16'hFFFF));
            end
            set_cfg(w, h, sx, sy, FW'($urandom), FW'($urandom), $urandom_range(0, 8), $urandom_range(0, 8));
            g0 = got.size(); d0 = done_cnt; n = w * h;
            do_start();
            run_until_done(400, 2, to);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout got %b exp 0", f, to); end
            checks++; if (got.size() - g0 !== n) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", f, got.size() - g0, n); end
            for (int i = 0; i < n && g0 + i < got.size(); i++) begin
                checks++; if (got[g0+i] !== model(i % w, i / w)) begin errors++; $display("FAIL rand%0d_beat%0d got %h exp %h", f, i, got[g0+i], model(i % w, i / w)); end
            end
            checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rand%0d_done got %0d exp 1", f, done_cnt - d0); end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_backpressure();
        test_abort();
        test_zero_dim();
        test_start_busy();
        test_clamp();
        test_random();
        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
